// File: rtl/huff_pkg.sv
// Shared types and default sizing for the Huffman bit packer.
package huff_pkg;

  localparam int unsigned DEF_OUT_W   = 32;
  localparam int unsigned DEF_MAX_LEN = 16;

  typedef enum logic [1:0] {
    FILL_ST,
    DRAIN_ST,
    LAST_ST
  } state_t;

endpackage

// File: rtl/huff_code_align.sv
// Masks a right-aligned code to its clamped length and places it directly below the
// fill point of an MSB-aligned accumulator.
module huff_code_align #(
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned ACC_W   = OUT_W + MAX_LEN,
  parameter int unsigned FILL_W  = $clog2(ACC_W + 1)
) (
  input  logic [MAX_LEN-1:0] code_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [FILL_W-1:0]  fill_i,
  output logic [ACC_W-1:0]   aligned_o,
  output logic [LEN_W-1:0]   len_eff_o
);

  logic [ACC_W-1:0]  mask;
  logic [ACC_W-1:0]  field;
  logic [FILL_W:0]   shamt;

  always_comb begin
    len_eff_o = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
    mask      = (ACC_W'(1) << len_eff_o) - ACC_W'(1);
    field     = ACC_W'(code_i) & mask;
    // Only meaningful while fill_i < OUT_W; other states never accept, so a wrapped
    // shift amount there is harmless.
    shamt     = (FILL_W + 1)'(ACC_W) - {1'b0, fill_i} - (FILL_W + 1)'(len_eff_o);
    aligned_o = field << shamt;
  end

endmodule

// File: rtl/huff_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into OUT_W-bit words, with an
// end-of-stream flush that emits a final partial word tagged out_last.
module huff_bit_packer
  import huff_pkg::*;
#(
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAX_LEN-1:0]         in_code,
  input  logic [LEN_W-1:0]           in_len,
  input  logic                       in_flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(OUT_W+1)-1:0] out_nbits,
  output logic                       out_last
);

  localparam int unsigned AccW  = OUT_W + MAX_LEN;
  localparam int unsigned FillW = $clog2(AccW + 1);
  localparam int unsigned NbW   = $clog2(OUT_W + 1);

  state_t            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [AccW-1:0]   aligned;
  logic [LEN_W-1:0]  len_eff;
  logic              accept, emit;

  logic              in_ready_d, out_valid_d, out_last_d;
  logic [OUT_W-1:0]  out_data_d;
  logic [NbW-1:0]    out_nbits_d;

  huff_code_align #(
    .OUT_W  (OUT_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .ACC_W  (AccW),
    .FILL_W (FillW)
  ) u_align (
    .code_i   (in_code),
    .len_i    (in_len),
    .fill_i   (fill_q),
    .aligned_o(aligned),
    .len_eff_o(len_eff)
  );

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    unique case (state_q)
      FILL_ST: begin
        if (accept) begin
          acc_d  = acc_q | aligned;
          fill_d = fill_q + FillW'(len_eff);
          if (in_flush) state_d = DRAIN_ST;
        end else if (emit) begin
          acc_d  = acc_q << OUT_W;
          fill_d = fill_q - FillW'(OUT_W);
        end
      end
      DRAIN_ST: begin
        if (emit) begin
          acc_d  = acc_q << OUT_W;
          fill_d = fill_q - FillW'(OUT_W);
        end else if (fill_q <= FillW'(OUT_W)) begin
          state_d = LAST_ST;
        end
      end
      LAST_ST: begin
        if (emit) begin
          acc_d   = '0;
          fill_d  = '0;
          state_d = FILL_ST;
        end
      end
      default: state_d = FILL_ST;
    endcase
  end

  // Outputs are registered from next state, giving one cycle from completing accept to word.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = acc_d[AccW-1 -: OUT_W];
    out_nbits_d = NbW'(OUT_W);
    unique case (state_d)
      FILL_ST: begin
        in_ready_d  = fill_d < FillW'(OUT_W);
        out_valid_d = fill_d >= FillW'(OUT_W);
      end
      DRAIN_ST: out_valid_d = fill_d > FillW'(OUT_W);
      LAST_ST: begin
        out_valid_d = 1'b1;
        out_nbits_d = NbW'(fill_d);
        out_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= FILL_ST;
      acc_q     <= '0;
      fill_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_nbits <= out_nbits_d;
      out_last  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Bench for huff_bit_packer (OUT_W=8, MAX_LEN=4): directed cases plus random codes
// checked against a bit-queue model of the packed stream.
module tb_huff_bit_packer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       in_valid, in_ready, in_flush;
  logic [3:0] in_code;
  logic [2:0] in_len;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic [3:0] out_nbits;

  huff_bit_packer #(
    .OUT_W  (8),
    .MAX_LEN(4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_len   (in_len),
    .in_flush (in_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_nbits(out_nbits),
    .out_last (out_last)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         last;
  } word_t;

  bit    bits[$];
  word_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rand_ready_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void pop_word(input int n, input bit last);
    word_t w;
    w.data  = '0;
    w.nbits = n;
    w.last  = last;
    for (int i = 0; i < n; i++) w.data[7-i] = bits.pop_front();
    exp_q.push_back(w);
  endfunction

  // Stream model: codes concatenated MSB-first, cut into 8-bit words; a flush closes
  // the stream with a final word holding whatever remains (0..8 bits).
  function automatic void model_accept(input logic [3:0] code, input int len, input bit flush);
    int l;
    l = (len > 4) ? 4 : len;
    for (int i = l - 1; i >= 0; i--) bits.push_back(code[i]);
    if (!flush) begin
      while (bits.size() >= 8) pop_word(8, 1'b0);
    end else begin
      while (bits.size() > 8) pop_word(8, 1'b0);
      pop_word(bits.size(), 1'b1);
    end
  endfunction

  task automatic send(input logic [3:0] code, input int len, input bit flush);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    in_len   = 3'(len);
    in_flush = flush;
    while (!done && n < 200) begin
      @(negedge Clock);
      if (in_ready) begin
        @(posedge Clock);
        model_accept(code, len, flush);
        done = 1'b1;
      end else begin
        n++;
      end
    end
    if (!done) @(posedge Clock);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    if (!done) check_eq("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: a word is taken when valid && ready hold into the next edge.
  initial begin
    word_t w;
    forever begin
      @(negedge Clock);
      if (!Reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_word", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check_eq("word_data", {24'd0, out_data}, {24'd0, w.data});
          check_eq("word_nbits", {28'd0, out_nbits}, 32'(w.nbits));
          check_eq("word_last", {31'd0, out_last}, {31'd0, w.last});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [3:0] rc;
    int rl;
    bit rf;

    Reset = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    in_len = '0;
    in_flush = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_out_nbits", {28'd0, out_nbits}, 32'd0);
    check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Three codes completing one word, presented the cycle after the last accept
    out_ready = 1'b1;
    send(4'b0101, 3, 1'b0);
    send(4'b0011, 2, 1'b0);
    send(4'b0010, 3, 1'b0);
    check_eq("latency_valid", {31'd0, out_valid}, 32'd1);
    check_eq("latency_data", {24'd0, out_data}, 32'hBA);
    wait_idle("idle_ba");

    send(4'b0101, 3, 1'b1);
    wait_idle("idle_a0");
    check_eq("ready_after_last", {31'd0, in_ready}, 32'd1);

    send(4'hF, 1, 1'b0);
    send(4'h0, 0, 1'b1);
    wait_idle("idle_mask");

    // Backpressure holds the full word and blocks input
    out_ready = 1'b0;
    send(4'hF, 4, 1'b0);
    send(4'hF, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock);
      #1;
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_data", {24'd0, out_data}, 32'hFF);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(4'hF, 4, 1'b0);
    send(4'h0, 0, 1'b1);
    wait_idle("idle_bp");

    send(4'h0, 0, 1'b1);
    wait_idle("idle_empty");

    // Reset while draining discards everything
    out_ready = 1'b0;
    send(4'hF, 4, 1'b0);
    send(4'h7, 3, 1'b0);
    send(4'hF, 4, 1'b1);
    check_eq("drain_valid", {31'd0, out_valid}, 32'd1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    bits.delete();
    exp_q.delete();
    check_eq("rst_drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_drain_last", {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    check_eq("rst_drain_quiet", {31'd0, out_valid}, 32'd0);
    send(4'h0, 0, 1'b1);
    wait_idle("idle_rst_drain");

    // Random codes, lengths (including over-length) and backpressure
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rc = 4'($urandom);
      rl = $urandom_range(0, 7);
      rf = ($urandom_range(0, 7) == 0) || (rl == 0);
      send(rc, rl, rf);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge Clock);
      #0;
    end
    send(4'h0, 0, 1'b1);
    rand_ready_en = 1'b0;
    @(posedge Clock);
    #2;
    out_ready = 1'b1;
    wait_idle("idle_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huff_bit_packer.md
HUFF_BIT_PACKER -- requirements
Module: huff_bit_packer

Interface
REQ-001 SHALL have parameter OUT_W, default 32, meaning output word width in bits (>= MAX_LEN).
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning maximum Huffman code length in bits.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_LEN+1), meaning width of length fields.
REQ-004 SHALL have one clock and a synchronous, active-high reset; all ports are listed below as name, direction, width, meaning.
REQ-005 SHALL have port Clock, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, code beat valid.
REQ-008 SHALL have port in_ready, output, 1, code beat accepted when in_valid && in_ready at the Clock edge.
REQ-009 SHALL have port in_code, input, MAX_LEN, right-aligned code; the first emitted bit is in_code[in_len-1].
REQ-010 SHALL have port in_len, input, LEN_W, code length 0..MAX_LEN.
REQ-011 SHALL have port in_flush, input, 1, marks this beat as end of stream.
REQ-012 SHALL have port out_valid, output, 1, output word valid.
REQ-013 SHALL have port out_ready, input, 1, output word taken when out_valid && out_ready at the Clock edge.
REQ-014 SHALL have port out_data, output, OUT_W, packed bits, MSB first.
REQ-015 SHALL have port out_nbits, output, $clog2(OUT_W+1), count of meaningful bits in out_data.
REQ-016 SHALL have port out_last, output, 1, final word of stream.

Function
REQ-017 SHALL hold an accumulator ACC of OUT_W+MAX_LEN bits and a fill counter FILL, with valid bits left-aligned at the ACC MSB.
REQ-018 SHALL, on accept, append the low in_len bits of in_code directly below the current FILL bits, then FILL += in_len.
REQ-019 SHALL mask in_code bits at or above in_len so they are not packed.
REQ-020 SHALL treat in_len > MAX_LEN as MAX_LEN.
REQ-021 SHALL treat in_len = 0 as a no-op on ACC (valid only with in_flush).
REQ-022 SHALL implement a state machine with states FILL_ST, DRAIN_ST, LAST_ST.
REQ-023 SHALL, in FILL_ST, drive in_ready = (FILL < OUT_W) and out_valid = (FILL >= OUT_W), with out_data = ACC[top OUT_W], out_nbits = OUT_W, out_last = 0.
REQ-024 SHALL, on an output handshake, shift ACC left by OUT_W and set FILL -= OUT_W in the same edge.
REQ-025 SHALL never accept an input and emit an output in the same cycle, since in_ready and out_valid are mutually exclusive by FILL.
REQ-026 SHALL, on an accept with in_flush = 1, append the code and then enter DRAIN_ST.
REQ-027 SHALL drive in_ready = 0 in DRAIN_ST and LAST_ST.
REQ-028 SHALL, in DRAIN_ST, emit full words while FILL > OUT_W, then move to LAST_ST.
REQ-029 SHALL, in LAST_ST, present out_valid = 1, out_data = the remaining FILL bits MSB-aligned with zero padding below, out_nbits = FILL, and out_last = 1.
REQ-030 SHALL, when FILL = 0 at flush, emit a single word with out_data = 0, out_nbits = 0 and out_last = 1.
REQ-031 SHALL, on the LAST_ST handshake, clear ACC and FILL and return to FILL_ST.
REQ-032 SHALL keep out_data, out_nbits and out_last stable while out_valid && !out_ready, so that backpressure loses no bits.
REQ-033 SHALL have 1-cycle latency: a word that becomes full is presented on the cycle after the completing accept.

Reset
REQ-034 SHALL, while Reset = 1 at the Clock edge, set state = FILL_ST, ACC = 0 and FILL = 0, with outputs out_valid = 0, out_data = 0, out_nbits = 0, out_last = 0 and in_ready = 0.
REQ-035 SHALL drive in_ready = 1 from the first cycle after Reset deasserts.
REQ-036 SHALL discard partial data on a reset asserted mid-stream or mid-drain, emitting no last word.

Structure
REQ-037 SHALL place the state enum (FILL_ST, DRAIN_ST, LAST_ST) and the default OUT_W/MAX_LEN constants in shared package huff_pkg.
REQ-038 SHALL implement the combinational masking and alignment of in_code to the ACC insertion position in one sub-module, huff_code_align.

Verification (bench with OUT_W=8, MAX_LEN=4)
REQ-039 SHALL cover: codes (101,3),(11,2),(010,3) with out_ready = 1 -> one word 0xBA, nbits 8, last 0.
REQ-040 SHALL cover: (101,3,flush) -> word 0xA0, nbits 3, last 1, then in_ready = 1.
REQ-041 SHALL cover: in_code = 4'hF with len 1, then len 0 with flush -> word 0x80, nbits 1, last 1.
REQ-042 SHALL cover: fill to 12 bits (1111,4)x3 with out_ready = 0 for 5 cycles -> out_data stays 0xFF and in_ready = 0; release -> 0xFF, then after flush 0xF0 with nbits 4 and last 1.
REQ-043 SHALL cover: flush with FILL = 0 -> out_data 0x00, nbits 0, last 1.
REQ-044 SHALL cover: Reset asserted in DRAIN_ST -> next cycle out_valid = 0 and FILL = 0, with no last word emitted.
